// File: rtl/mat_pkg.sv
// Shared sizing and state encoding for the mat_mul result path.
package mat_pkg;
    localparam int N_ELEM = 16;
    localparam int ADDR_W = 4;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} drain_state_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Small synchronous first-word-fall-through FIFO; head word is visible on
// o_rdata whenever o_empty is low.
module sync_fifo_fwft #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_count;
    logic             w_wr, w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rp];
    assign w_wr    = i_push & ~o_full;
    assign w_rd    = i_pop & ~o_empty;

    // Storage is cleared on reset so the head word reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= i_wdata;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_rd) r_rp <= r_rp + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mat_result_drain.sv
// Sweeps mat_mul's result port after done rises and streams the products out
// in address order; issue is credit-limited so captures never overflow.
module mat_result_drain
    import mat_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done,
    output logic [ADDR_W-1:0] address,
    input  logic [PROD_W-1:0] product,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PROD_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              overrun
);
    localparam int CNT_W  = $clog2(N_ELEM) + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    drain_state_t      r_state, w_next;
    logic              r_done_q, r_overrun;
    logic [CNT_W-1:0]  r_issue_cnt, r_cap_cnt, w_inflight;
    logic [RD_LAT-1:0] r_vpipe;
    logic [FCNT_W-1:0] w_fcount;
    logic [PROD_W:0]   w_head;
    logic              w_full, w_empty, w_start, w_issue, w_cap, w_pop;
    logic              w_credit, w_cap_last;

    assign w_start    = done & ~r_done_q;
    assign w_cap      = r_vpipe[RD_LAT-1];
    assign w_cap_last = (r_cap_cnt == CNT_W'(N_ELEM-1));
    assign w_pop      = m_ready & ~w_empty;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CNT_W'(r_vpipe[i]);
    end

    // Words already buffered plus words still in the read pipe must fit.
    assign w_credit = (int'(w_fcount) + int'(w_inflight)) < FIFO_DEPTH;

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        address = '0;
        case (r_state)
            IDLE:  if (w_start) w_next = ISSUE;
            ISSUE: begin
                address = r_issue_cnt[ADDR_W-1:0];
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (r_issue_cnt == CNT_W'(N_ELEM-1)) w_next = DRAIN;
                end
            end
            DRAIN: begin
                address = ADDR_W'(N_ELEM-1);
                if (w_inflight == '0 && w_empty) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_done_q    <= 1'b0;
            r_overrun   <= 1'b0;
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            r_vpipe     <= '0;
        end else begin
            r_state  <= w_next;
            r_done_q <= done;
            if (w_start && r_state != IDLE) r_overrun <= 1'b1;
            if (w_issue) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            else if (r_state == DRAIN && w_next == IDLE) r_issue_cnt <= '0;
            if (w_cap) r_cap_cnt <= r_cap_cnt + CNT_W'(1);
            else if (r_state == DRAIN && w_next == IDLE) r_cap_cnt <= '0;
            r_vpipe[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(w_cap && w_full));
    end

    sync_fifo_fwft #(.WIDTH(PROD_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_cap),
        .i_wdata ({product, w_cap_last}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_fcount),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_valid = ~w_empty;
    assign m_data  = w_head[PROD_W:1];
    assign m_last  = w_head[0];
    assign busy    = (r_state != IDLE);
    assign overrun = r_overrun;
endmodule

// File: tb/tb_mat_result_drain.sv
// Directed bench: two drains (read latency 1 and 3) against a behavioural
// mat_mul returning 3*address+7.
module tb_mat_result_drain;
    import mat_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0;
    logic done1 = 1'b0, done3 = 1'b0, rdy1 = 1'b1, rdy3 = 1'b1;
    logic [ADDR_W-1:0] addr1, addr3;
    logic [PROD_W-1:0] prod1, prod3, p3a, p3b, data1, data3;
    logic v1, v3, l1, l3, busy1, busy3, ovr1, ovr3;
    logic [3:0] bp_pat = 4'b1001;

    int errors = 0, checks = 0, cyc = 0, rise = 0;
    int first1 = -1, first3 = -1, ahead_max = 0;
    logic [PROD_W-1:0] q1d[$], q3d[$];
    logic q1l[$], q3l[$];
    int q1t[$], q3t[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) prod1 <= 32'(addr1) * 3 + 7;
    always @(posedge clk) begin
        p3a   <= 32'(addr3) * 3 + 7;
        p3b   <= p3a;
        prod3 <= p3b;
    end

    mat_result_drain #(.RD_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .done(done1), .address(addr1), .product(prod1),
        .m_valid(v1), .m_ready(rdy1), .m_data(data1), .m_last(l1),
        .busy(busy1), .overrun(ovr1));

    mat_result_drain #(.RD_LAT(3), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .done(done3), .address(addr3), .product(prod3),
        .m_valid(v3), .m_ready(rdy3), .m_data(data3), .m_last(l3),
        .busy(busy3), .overrun(ovr3));

    // Handshakes are sampled mid-cycle; the stamp is the edge that completes them.
    always @(negedge clk) begin
        if (busy1 && (int'(addr1) - q1d.size()) > ahead_max) ahead_max = int'(addr1) - q1d.size();
        if (v1 && first1 < 0) first1 = cyc;
        if (v3 && first3 < 0) first3 = cyc;
        if (v1 && rdy1) begin q1d.push_back(data1); q1l.push_back(l1); q1t.push_back(cyc + 1); end
        if (v3 && rdy3) begin q3d.push_back(data3); q3l.push_back(l3); q3t.push_back(cyc + 1); end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        q1d.delete(); q1l.delete(); q1t.delete();
        q3d.delete(); q3l.delete(); q3t.delete();
        first1 = -1; first3 = -1; ahead_max = 0;
    endtask

    task automatic pulse(input int which);
        @(posedge clk); #1;
        if (which == 1) done1 = 1'b1; else done3 = 1'b1;
        rise = cyc;
        @(posedge clk); #1;
        done1 = 1'b0; done3 = 1'b0;
    endtask

    task automatic wait_idle(input int which, input string tag);
        for (int i = 0; i < 300; i++) begin
            if (which == 1 ? !busy1 : !busy3) break;
            @(posedge clk); #1;
        end
        chk(tag, 64'(which == 1 ? busy1 : busy3), 64'(0));
    endtask

    task automatic check_sweep(input int which, input string tag);
        int n;
        n = (which == 1) ? q1d.size() : q3d.size();
        chk({tag, "_count"}, 64'(n), 64'(N_ELEM));
        for (int i = 0; i < n && i < N_ELEM; i++) begin
            chk({tag, "_data"}, 64'(which == 1 ? q1d[i] : q3d[i]), 64'(3 * i + 7));
            chk({tag, "_last"}, 64'(which == 1 ? q1l[i] : q3l[i]), 64'(i == N_ELEM - 1));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_address", 64'(addr1), 64'(0));
        chk("rst_valid",   64'(v1),    64'(0));
        chk("rst_data",    64'(data1), 64'(0));
        chk("rst_last",    64'(l1),    64'(0));
        chk("rst_busy",    64'(busy1), 64'(0));
        chk("rst_overrun", 64'(ovr1),  64'(0));
        chk("rst_valid3",  64'(v3),    64'(0));
        chk("rst_overrun3", 64'(ovr3), 64'(0));
        rst_n = 1'b1;

        // Basic sweep, consumer always ready.
        clear_mon();
        pulse(1);
        chk("basic_busy_rise", 64'(busy1), 64'(1));
        wait_idle(1, "basic_idle");
        check_sweep(1, "basic");
        chk("basic_first_valid", 64'(first1 - rise), 64'(3));
        if (q1t.size() == N_ELEM) begin
            chk("basic_back2back", 64'(q1t[N_ELEM-1] - q1t[0]), 64'(N_ELEM - 1));
            chk("basic_sweep_len", 64'(q1t[N_ELEM-1] - rise), 64'(N_ELEM + 3));
        end
        chk("basic_address_idle", 64'(addr1), 64'(0));

        // Backpressure: ready pattern 1,0,0,1.
        clear_mon();
        pulse(1);
        for (int i = 0; i < 400; i++) begin
            if (!busy1) break;
            rdy1 = bp_pat[2'(i)];
            @(posedge clk); #1;
        end
        rdy1 = 1'b1;
        chk("bp_idle", 64'(busy1), 64'(0));
        check_sweep(1, "bp");
        chk("bp_ahead_le_depth", 64'(ahead_max <= 4), 64'(1));
        chk("bp_no_overrun", 64'(ovr1), 64'(0));

        // Read latency 3.
        clear_mon();
        pulse(3);
        wait_idle(3, "lat3_idle");
        check_sweep(3, "lat3");
        chk("lat3_first_valid", 64'(first3 - rise), 64'(5));

        // Overrun: second edge during word 6.
        clear_mon();
        pulse(1);
        for (int i = 0; i < 50 && q1d.size() < 6; i++) begin @(posedge clk); #1; end
        chk("ovr_reached6", 64'(q1d.size() >= 6), 64'(1));
        pulse(1);
        chk("ovr_set", 64'(ovr1), 64'(1));
        wait_idle(1, "ovr_idle");
        repeat (10) @(posedge clk);
        #1;
        check_sweep(1, "ovr");
        chk("ovr_no_restart", 64'(busy1), 64'(0));
        chk("ovr_sticky", 64'(ovr1), 64'(1));

        // Reset in the middle of a sweep.
        clear_mon();
        pulse(1);
        for (int i = 0; i < 50 && q1d.size() < 5; i++) begin @(posedge clk); #1; end
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_address", 64'(addr1), 64'(0));
        chk("mrst_valid",   64'(v1),    64'(0));
        chk("mrst_data",    64'(data1), 64'(0));
        chk("mrst_last",    64'(l1),    64'(0));
        chk("mrst_busy",    64'(busy1), 64'(0));
        chk("mrst_overrun", 64'(ovr1),  64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        pulse(1);
        wait_idle(1, "mrst_idle");
        check_sweep(1, "mrst");

        // done held high for 100 cycles yields one sweep only.
        clear_mon();
        @(posedge clk); #1;
        done1 = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        done1 = 1'b0;
        chk("held_idle", 64'(busy1), 64'(0));
        check_sweep(1, "held");
        chk("held_no_overrun", 64'(ovr1), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
